// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Default sizing constants and slice-index helper for regfile_mp.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int NUM_RD_DEF = 4;
    localparam int NUM_WR_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;

    // Low bit of slice idx in a packed vector of width-sized fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wr_arb.sv
// ============================================================================
// Module : regfile_wr_arb
// Brief  : Per-register write hit, winning port and next pending bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int WP_W     = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [NUM_WR-1:0]           wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]    wr_addr_i,
    input  logic                        rsv_en_i,
    input  logic [ADDR_W-1:0]           rsv_addr_i,
    input  logic [DEPTH-1:0]            pend_q_i,
    output logic [DEPTH-1:0]            hit_o,
    output logic [DEPTH-1:0][WP_W-1:0]  win_o,
    output logic [DEPTH-1:0]            pend_d_o
);

    logic w_hit;

    always_comb begin
        hit_o    = '0;
        win_o    = '0;
        pend_d_o = '0;
        w_hit    = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            w_hit = 1'b0;
            if (!(ZERO_REG != 0 && r == 0)) begin
                // Descending scan so the lowest-numbered enabled port wins.
                for (int p = NUM_WR - 1; p >= 0; p--) begin
                    if (wr_en_i[p] &&
                        wr_addr_i[slice_lo(p, ADDR_W) +: ADDR_W] == ADDR_W'(r)) begin
                        w_hit    = 1'b1;
                        win_o[r] = WP_W'(p);
                    end
                end
                hit_o[r] = w_hit;
                if (rsv_en_i && rsv_addr_i == ADDR_W'(r))
                    pend_d_o[r] = 1'b1;
                else if (w_hit)
                    pend_d_o[r] = 1'b0;
                else
                    pend_d_o[r] = pend_q_i[r];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module : regfile_mp
// Brief  : Multi-port register file with pending scoreboard and optional bypass.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [DEPTH-1:0]           pending_vec
);

    localparam int WP_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [DATA_W-1:0]          regs_q [DEPTH];
    logic [DATA_W-1:0]          regs_d [DEPTH];
    logic [DEPTH-1:0]           pend_q, pend_d, hit;
    logic [DEPTH-1:0][WP_W-1:0] win;
    logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]          rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0]          w_ra;

    regfile_wr_arb #(
        .NUM_WR   (NUM_WR),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .WP_W     (WP_W),
        .ZERO_REG (ZERO_REG)
    ) u_wr_arb (
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .pend_q_i   (pend_q),
        .hit_o      (hit),
        .win_o      (win),
        .pend_d_o   (pend_d)
    );

    always_comb begin
        for (int r = 0; r < DEPTH; r++)
            regs_d[r] = hit[r] ? wr_data[slice_lo(int'(win[r]), DATA_W) +: DATA_W]
                               : regs_q[r];
    end

    // Out-of-range addresses read as zero/not-pending; register 0 under
    // ZERO_REG is never written or reserved, so it naturally reads zero.
    always_comb begin
        rd_data_d = '0;
        rd_pend_d = '0;
        w_ra      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
            if (int'(w_ra) < DEPTH) begin
                if (BYPASS != 0) begin
                    rd_data_d[slice_lo(i, DATA_W) +: DATA_W] = regs_d[w_ra];
                    rd_pend_d[i]                             = pend_d[w_ra];
                end else begin
                    rd_data_d[slice_lo(i, DATA_W) +: DATA_W] = regs_q[w_ra];
                    rd_pend_d[i]                             = pend_q[w_ra];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++)
                regs_q[r] <= '0;
            pend_q    <= '0;
            rd_data_q <= '0;
            rd_pend_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++)
                regs_q[r] <= regs_d[r];
            pend_q    <= pend_d;
            rd_data_q <= rd_data_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_pending  = rd_pend_q;
    assign pending_vec = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module : tb_regfile_mp
// Brief  : Directed self-checking bench; bypass and non-bypass instances share stimulus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int NR = 4;
    localparam int NW = 4;
    localparam int DW = 32;
    localparam int DP = 32;
    localparam int AW = 5;

    logic             clk;
    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;

    logic [NR*DW-1:0] b_rd_data,  n_rd_data;
    logic [NR-1:0]    b_rd_pend,  n_rd_pend;
    logic [DP-1:0]    b_pvec,     n_pvec;

    int n_cmp = 0;
    int n_err = 0;

    regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_pending(b_rd_pend), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pending_vec(b_pvec)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(n_rd_data),
        .rd_pending(n_rd_pend), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pending_vec(n_pvec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [DW-1:0] bd(input int p);
        return b_rd_data[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] nd(input int p);
        return n_rd_data[p*DW +: DW];
    endfunction

    initial begin
        rst = 1'b1;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state: every address on all four ports
        for (int g = 0; g < DP / NR; g++) begin
            for (int p = 0; p < NR; p++) rd(p, g * NR + p);
            tick();
            for (int p = 0; p < NR; p++) begin
                chk($sformatf("rst_data_r%0d", g * NR + p), 64'(bd(p)), 64'h0);
                chk($sformatf("rst_pend_r%0d", g * NR + p), 64'(b_rd_pend[p]), 64'h0);
            end
        end
        chk("rst_pvec", 64'(b_pvec), 64'h0);

        // Four distinct writes in one cycle
        wr(0, 1, 32'h11); wr(1, 2, 32'h22); wr(2, 3, 32'h33); wr(3, 4, 32'h44);
        tick();
        idle();
        for (int p = 0; p < NR; p++) rd(p, p + 1);
        tick();
        chk("mw_r1", 64'(bd(0)), 64'h11);
        chk("mw_r2", 64'(bd(1)), 64'h22);
        chk("mw_r3", 64'(bd(2)), 64'h33);
        chk("mw_r4", 64'(bd(3)), 64'h44);
        chk("mw_r4_nb", 64'(nd(3)), 64'h44);

        // Same-address collision: port 1 beats port 2
        wr(2, 5, 32'hAAAA); wr(1, 5, 32'hBBBB);
        tick();
        idle();
        rd(0, 5);
        tick();
        chk("coll_r5", 64'(bd(0)), 64'hBBBB);

        // Bypass vs non-bypass on a same-cycle write
        wr(0, 7, 32'h1234);
        tick();
        idle();
        wr(0, 7, 32'hDEAD);
        rd(0, 7);
        tick();
        idle();
        chk("byp_r7", 64'(bd(0)), 64'hDEAD);
        chk("nobyp_r7", 64'(nd(0)), 64'h1234);
        tick();
        chk("nobyp_r7_later", 64'(nd(0)), 64'hDEAD);

        // Scoreboard: reserve, reserve+write, write alone
        rsv_en = 1'b1; rsv_addr = AW'(9);
        rd(0, 9);
        tick();
        idle();
        chk("rsv_pvec9", 64'(b_pvec[9]), 64'h1);
        chk("rsv_byp_pend", 64'(b_rd_pend[0]), 64'h1);
        chk("rsv_nobyp_pend", 64'(n_rd_pend[0]), 64'h0);
        rsv_en = 1'b1; rsv_addr = AW'(9); wr(0, 9, 32'h55);
        tick();
        idle();
        chk("rsvwr_pvec9", 64'(b_pvec[9]), 64'h1);
        chk("rsvwr_data9", 64'(bd(0)), 64'h55);
        wr(0, 9, 32'h99);
        tick();
        idle();
        chk("wr_pvec9", 64'(b_pvec[9]), 64'h0);
        chk("wr_byp_data9", 64'(bd(0)), 64'h99);
        chk("wr_byp_pend9", 64'(b_rd_pend[0]), 64'h0);
        chk("wr_nobyp_pend9", 64'(n_rd_pend[0]), 64'h1);

        // Zero register: ignored write/reserve, and port 1 write to r6 still lands
        wr(0, 0, 32'hFFFF); wr(1, 6, 32'h66); rsv_en = 1'b1; rsv_addr = '0;
        rd(0, 0);
        tick();
        idle();
        chk("zr_byp_data", 64'(bd(0)), 64'h0);
        chk("zr_pvec", 64'(b_pvec), 64'h0);
        rd(1, 6);
        tick();
        chk("zr_data", 64'(bd(0)), 64'h0);
        chk("zr_pend", 64'(b_rd_pend[0]), 64'h0);
        chk("zr_r6", 64'(bd(1)), 64'h66);

        // Asynchronous reset mid-cycle
        wr(0, 3, 32'h3333); rsv_en = 1'b1; rsv_addr = AW'(10);
        tick();
        idle();
        rd(0, 3);
        tick();
        chk("pre_rst_r3", 64'(bd(0)), 64'h3333);
        chk("pre_rst_pvec10", 64'(b_pvec[10]), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rd_data", 64'(b_rd_data), 64'h0);
        chk("async_pvec", 64'(b_pvec), 64'h0);
        chk("async_rd_data_nb", 64'(n_rd_data), 64'h0);
        wr(0, 3, 32'h77); rsv_en = 1'b1; rsv_addr = AW'(3);
        tick();
        rst = 1'b0;
        idle();
        tick();
        chk("post_rst_r3", 64'(bd(0)), 64'h0);
        chk("post_rst_pend3", 64'(b_rd_pend[0]), 64'h0);
        chk("post_rst_pvec", 64'(b_pvec), 64'h0);

        // First post-reset edge operates normally
        wr(2, 3, 32'hCAFE);
        tick();
        idle();
        tick();
        chk("post_rst_wr_r3", 64'(bd(0)), 64'hCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
